// File: rtl/pipeline_drain_pkg.sv
// pipeline_drain_pkg: shared widths, address offset and entry layout for the drain stage.
package pipeline_drain_pkg;
    localparam int ADDRESS_WIDTH = 8;
    localparam int ID_WIDTH = 4;
    localparam int PIPELINE_DEPTH = 4;
    // Sum of the per-stage offsets (i+1)*3 added by the jumbling pipeline.
    localparam logic [ADDRESS_WIDTH-1:0] TOTAL_OFFSET =
        ADDRESS_WIDTH'((3 * PIPELINE_DEPTH * (PIPELINE_DEPTH + 1) / 2) % (1 << ADDRESS_WIDTH));
    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [ID_WIDTH-1:0] id;
    } entry_t;
    function automatic logic [ADDRESS_WIDTH-1:0] recover_addr(input logic [ADDRESS_WIDTH-1:0] a);
        return a - TOTAL_OFFSET;
    endfunction
endpackage

// File: rtl/stall_fifo.sv
// stall_fifo: synchronous FIFO with full/empty flags; read data reads zero while empty.
module stall_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic push, pop;
    assign full = count_q == CW'(DEPTH);
    assign empty = count_q == '0;
    assign push = wr_en & ~full;
    assign pop = rd_en & ~empty;
    assign rd_data = empty ? '0 : mem[rd_ptr_q];
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end
endmodule

// File: rtl/pipeline_drain.sv
// pipeline_drain: buffers the last pipeline stage output, un-jumbles addresses and
// flags transaction IDs that arrive out of sequence.
module pipeline_drain
    import pipeline_drain_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] in_address,
    input  logic [ID_WIDTH-1:0]      in_id,
    input  logic                     in_valid,
    output logic                     out_stall,
    output logic [ADDRESS_WIDTH-1:0] out_address,
    output logic [ID_WIDTH-1:0]      out_id,
    output logic                     out_valid,
    input  logic                     in_stall,
    output logic                     id_error,
    output logic [7:0]               error_count
);
    entry_t wr_entry, rd_entry;
    logic full, empty, accept, pop, mismatch;
    logic [ID_WIDTH-1:0] expected_id_q, expected_id_d;
    logic [7:0] error_count_q, error_count_d;
    logic id_error_q, id_error_d;
    // Stall comes from the registered full flag only, so a pop never frees a slot in the same cycle.
    assign out_stall = full;
    assign out_valid = ~empty;
    assign accept = in_valid & ~full;
    assign pop = ~empty & ~in_stall;
    assign wr_entry = '{addr: recover_addr(in_address), id: in_id};
    stall_fifo #(.WIDTH($bits(entry_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .wr_en(accept),
        .wr_data(wr_entry),
        .rd_en(pop),
        .rd_data(rd_entry),
        .full(full),
        .empty(empty)
    );
    assign out_address = rd_entry.addr;
    assign out_id = rd_entry.id;
    assign id_error = id_error_q;
    assign error_count = error_count_q;
    always_comb begin
        mismatch = accept && (in_id != expected_id_q);
        expected_id_d = accept ? in_id + ID_WIDTH'(1) : expected_id_q;
        error_count_d = (mismatch && error_count_q != 8'hFF) ? error_count_q + 8'd1 : error_count_q;
        id_error_d = id_error_q | mismatch;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            expected_id_q <= '0;
            error_count_q <= '0;
            id_error_q <= 1'b0;
        end else begin
            expected_id_q <= expected_id_d;
            error_count_q <= error_count_d;
            id_error_q <= id_error_d;
        end
    end
endmodule

// File: tb/tb_pipeline_drain.sv
// tb_pipeline_drain: directed checks of transfer, address recovery, back-pressure, ID checking and reset.
module tb_pipeline_drain;
    logic clk = 1'b0;
    logic reset, in_valid, in_stall, out_stall, out_valid, id_error;
    logic [7:0] in_address, out_address, error_count;
    logic [3:0] in_id, out_id;
    int n_asrt = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    pipeline_drain #(.FIFO_DEPTH(4)) dut (
        .clk(clk),
        .reset(reset),
        .in_address(in_address),
        .in_id(in_id),
        .in_valid(in_valid),
        .out_stall(out_stall),
        .out_address(out_address),
        .out_id(out_id),
        .out_valid(out_valid),
        .in_stall(in_stall),
        .id_error(id_error),
        .error_count(error_count)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic v, input logic [7:0] a, input logic [3:0] id);
        in_valid = v;
        in_address = a;
        in_id = id;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask
    initial begin
        reset = 1'b1;
        in_stall = 1'b0;
        drive(1'b0, 8'h00, 4'h0);
        step();
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_stall", 32'(out_stall), 32'd0);
        chk("rst_addr", 32'(out_address), 32'h00);
        chk("rst_id", 32'(out_id), 32'd0);
        chk("rst_err", 32'(id_error), 32'd0);
        chk("rst_cnt", 32'(error_count), 32'd0);
        reset = 1'b0;
        step();
        chk("idle_valid", 32'(out_valid), 32'd0);
        drive(1'b1, 8'h20, 4'd0);
        step();
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_addr", 32'(out_address), 32'h02);
        chk("single_id", 32'(out_id), 32'd0);
        chk("single_err", 32'(id_error), 32'd0);
        drive(1'b1, 8'h10, 4'd1);
        step();
        chk("wrap_addr", 32'(out_address), 32'hF2);
        chk("wrap_id", 32'(out_id), 32'd1);
        drive(1'b0, 8'h00, 4'd0);
        step();
        chk("drained_valid", 32'(out_valid), 32'd0);
        do_reset();
        in_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(8'h1E + i), 4'(i));
            step();
        end
        chk("fill_stall", 32'(out_stall), 32'd1);
        chk("fill_head", 32'(out_id), 32'd0);
        drive(1'b1, 8'h22, 4'd4);
        step();
        chk("held_stall", 32'(out_stall), 32'd1);
        chk("held_head", 32'(out_id), 32'd0);
        in_stall = 1'b0;
        step();
        chk("fullpop_id", 32'(out_id), 32'd1);
        chk("fullpop_stall", 32'(out_stall), 32'd0);
        step();
        chk("resume_id", 32'(out_id), 32'd2);
        chk("resume_stall", 32'(out_stall), 32'd0);
        drive(1'b0, 8'h00, 4'd0);
        step();
        chk("order_3", 32'(out_id), 32'd3);
        step();
        chk("order_4", 32'(out_id), 32'd4);
        chk("order_4_addr", 32'(out_address), 32'h04);
        step();
        chk("order_empty", 32'(out_valid), 32'd0);
        chk("fill_cnt", 32'(error_count), 32'd0);
        do_reset();
        drive(1'b1, 8'h40, 4'd0);
        step();
        drive(1'b1, 8'h41, 4'd1);
        step();
        chk("idc_1_err", 32'(id_error), 32'd0);
        drive(1'b1, 8'h42, 4'd3);
        step();
        chk("idc_3_err", 32'(id_error), 32'd1);
        chk("idc_3_cnt", 32'(error_count), 32'd1);
        drive(1'b1, 8'h43, 4'd4);
        step();
        chk("idc_4_cnt", 32'(error_count), 32'd1);
        drive(1'b1, 8'h44, 4'd15);
        step();
        chk("idc_15_cnt", 32'(error_count), 32'd2);
        drive(1'b1, 8'h45, 4'd0);
        step();
        chk("idc_0_cnt", 32'(error_count), 32'd2);
        chk("idc_0_err", 32'(id_error), 32'd1);
        drive(1'b0, 8'h00, 4'd0);
        step();
        in_stall = 1'b1;
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 8'(8'h50 + i), 4'(i));
            step();
        end
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        chk("pre_rst_stall", 32'(out_stall), 32'd0);
        chk("pre_rst_cnt", 32'(error_count), 32'd2);
        reset = 1'b1;
        drive(1'b1, 8'h60, 4'd4);
        step();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_cnt", 32'(error_count), 32'd0);
        chk("mid_rst_err", 32'(id_error), 32'd0);
        chk("mid_rst_addr", 32'(out_address), 32'h00);
        reset = 1'b0;
        in_stall = 1'b0;
        drive(1'b1, 8'h1E, 4'd0);
        step();
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_id", 32'(out_id), 32'd0);
        chk("post_rst_addr", 32'(out_address), 32'h00);
        chk("post_rst_err", 32'(id_error), 32'd0);
        do_reset();
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 8'h00, 4'd5);
            step();
        end
        chk("sat_cnt", 32'(error_count), 32'd255);
        chk("sat_err", 32'(id_error), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
